cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter_pkg.sv | 29 ++
 rtl/cdb_arbiter_if.sv | 40 ++++
 rtl/cdb_arbiter_rr_pick.sv | 47 ++++
 rtl/cdb_arbiter.sv | 104 ++++++++++
 tb/tb_cdb_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arb_types
// Shared types and default sizing for the common data bus (CDB) arbiter.
//   cdb_req_t  : one functional-unit result as broadcast on a CDB lane
//   fu_idx_w() : width of a requester index (at least 1 bit)
// ---------------------------------------------------------------------------
package cdb_arb_types;

    localparam int ROB_ID_W          = 6;
    localparam int PHY_REG_W         = 7;
    localparam int ARCH_REG_W        = 5;
    localparam int XLEN              = 32;

    localparam int N_FU_DEFAULT      = 4;
    localparam int CDB_WIDTH_DEFAULT = 2;

    typedef struct packed {
        logic [ROB_ID_W-1:0]   rob_id;
        logic [PHY_REG_W-1:0]  rd_phy;
        logic [ARCH_REG_W-1:0] rd_arch;
        logic [XLEN-1:0]       rd_value;
    } cdb_req_t;

    // A single requester still needs a 1-bit pointer.
    function automatic int fu_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the functional-unit request side and the CDB broadcast side of the
// arbiter.
//   flush     : ROB pipeline flush (synchronous)
//   fu_valid  : requester i holds a result
//   fu_req    : per-requester result payload
//   fu_ready  : per-requester grant; transfer when fu_valid & fu_ready
//   cdb_valid : per-lane broadcast valid (registered)
//   cdb_out   : per-lane broadcast payload (registered)
//   rr_ptr_o  : current round-robin start pointer
// Modports: master = functional units / ROB side, slave = arbiter.
// ---------------------------------------------------------------------------
interface cdb_arbiter_if
    import cdb_arb_types::*;
#(
    parameter int N_FU      = N_FU_DEFAULT,
    parameter int CDB_WIDTH = CDB_WIDTH_DEFAULT,
    parameter int FU_IDX    = fu_idx_w(N_FU)
) ();

    logic                           flush;
    logic     [N_FU-1:0]            fu_valid;
    cdb_req_t [N_FU-1:0]            fu_req;
    logic     [N_FU-1:0]            fu_ready;
    logic     [CDB_WIDTH-1:0]       cdb_valid;
    cdb_req_t [CDB_WIDTH-1:0]       cdb_out;
    logic     [FU_IDX-1:0]          rr_ptr_o;

    modport master (
        output flush, fu_valid, fu_req,
        input  fu_ready, cdb_valid, cdb_out, rr_ptr_o
    );

    modport slave (
        input  flush, fu_valid, fu_req,
        output fu_ready, cdb_valid, cdb_out, rr_ptr_o
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin finder: returns the first requester, walking
// from i_start upward with wrap at N_FU, that is requesting and not excluded.
//   i_req   : request vector
//   i_start : search start index (always < N_FU)
//   i_excl  : requesters already taken by an earlier stage
//   o_found : some eligible requester exists
//   o_idx   : index of that requester
// ---------------------------------------------------------------------------
module rr_pick
    import cdb_arb_types::*;
#(
    parameter int N_FU   = N_FU_DEFAULT,
    parameter int FU_IDX = fu_idx_w(N_FU)
) (
    input  logic [N_FU-1:0]   i_req,
    input  logic [FU_IDX-1:0] i_start,
    input  logic [N_FU-1:0]   i_excl,
    output logic              o_found,
    output logic [FU_IDX-1:0] o_idx
);

    int w_dist;
    int w_best;

    // Distance from the start pointer is computed with an explicit wrap so a
    // non-power-of-two N_FU walks 0..N_FU-1 only.
    always_comb begin
        // NOTE: every output and temporary gets a default before the loop so
        // no path leaves a value unassigned, which would infer a latch.
        o_found = 1'b0;
        o_idx   = '0;
        w_best  = 0;
        w_dist  = 0;
        for (int i = 0; i < N_FU; i++) begin
            w_dist = (i >= int'(i_start)) ? (i - int'(i_start))
                                          : (i + N_FU - int'(i_start));
            if (i_req[i] && !i_excl[i] && (!o_found || (w_dist < w_best))) begin
                o_found = 1'b1;
                o_idx   = FU_IDX'(i);
                w_best  = w_dist;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Grants up to CDB_WIDTH of N_FU functional-unit results per cycle in
// round-robin order and registers them onto the CDB lanes. The k-th grant in
// search order drives lane k. A flush suppresses all grants for the cycle.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : cdb_arbiter_if slave (flush, fu_valid/fu_req/fu_ready,
//         cdb_valid/cdb_out, rr_ptr_o)
// ---------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arb_types::*;
#(
    parameter int N_FU      = N_FU_DEFAULT,
    parameter int CDB_WIDTH = CDB_WIDTH_DEFAULT,
    parameter int FU_IDX    = fu_idx_w(N_FU)
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);

    logic [CDB_WIDTH:0][N_FU-1:0]     w_excl;
    logic [CDB_WIDTH-1:0]             w_found;
    logic [CDB_WIDTH-1:0][FU_IDX-1:0] w_idx;
    logic [N_FU-1:0]                  w_grant;
    logic                             w_accept;
    logic [FU_IDX-1:0]                w_last;
    logic [FU_IDX-1:0]                w_ptr_next;

    logic [FU_IDX-1:0]                r_rr_ptr;
    logic [CDB_WIDTH-1:0]             r_cdb_valid;
    cdb_req_t [CDB_WIDTH-1:0]         r_cdb_out;

    // Picker chain: each stage searches from the same pointer but skips the
    // requesters taken by earlier stages, so stage k finds the k-th grant.
    assign w_excl[0] = '0;

    for (genvar g = 0; g < CDB_WIDTH; g++) begin : g_lane
        rr_pick #(
            .N_FU   (N_FU),
            .FU_IDX (FU_IDX)
        ) u_pick (
            .i_req   (bus.fu_valid),
            .i_start (r_rr_ptr),
            .i_excl  (w_excl[g]),
            .o_found (w_found[g]),
            .o_idx   (w_idx[g])
        );

        assign w_excl[g+1] = w_excl[g] |
                             (w_found[g] ? (N_FU'(1) << w_idx[g]) : '0);
    end

    assign w_grant  = w_excl[CDB_WIDTH];
    assign w_accept = w_found[0] && !bus.flush;

    // Ready is gated by reset as well as flush so no transfer is signalled
    // while the lane registers are held clear.
    assign bus.fu_ready = (rst && !bus.flush) ? w_grant : '0;

    // Found bits fill from lane 0 upward, so the last found lane holds the
    // last grant in search order.
    always_comb begin
        w_last = '0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            if (w_found[k]) begin
                w_last = w_idx[k];
            end
        end
        if (int'(w_last) == N_FU - 1) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_last + FU_IDX'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the lane payloads are a handful of flops that reach every
            // snooper, so they are reset too rather than left undefined.
            r_cdb_valid <= '0;
            r_cdb_out   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            for (int k = 0; k < CDB_WIDTH; k++) begin
                r_cdb_valid[k] <= w_found[k] && !bus.flush;
                if (w_found[k] && !bus.flush) begin
                    r_cdb_out[k] <= bus.fu_req[w_idx[k]];
                end
            end
            if (w_accept) begin
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    assign bus.cdb_valid = r_cdb_valid;
    assign bus.cdb_out   = r_cdb_out;
    assign bus.rr_ptr_o  = r_rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed bench for cdb_arbiter with N_FU=4, CDB_WIDTH=2: reset, full
// contention, sparse request, wrap, flush, reset mid-broadcast, and a random
// fairness run checked against a small round-robin model.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_arb_types::*;

    localparam int N = 4;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    cdb_arbiter_if #(.N_FU(N), .CDB_WIDTH(W)) bus ();

    cdb_arbiter #(.N_FU(N), .CDB_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] exp_rdy [4] = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    int         exp_lo  [4] = '{0, 2, 0, 2};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic cdb_req_t pay(input int base, input int i);
        cdb_req_t r;
        r.rob_id   = ROB_ID_W'(base + i);
        r.rd_phy   = PHY_REG_W'(base + i + 1);
        r.rd_arch  = ARCH_REG_W'(i + 3);
        r.rd_value = {16'hA5A5, 16'(base * 16 + i)};
        return r;
    endfunction

    task automatic set_fu(input logic [3:0] v, input int base);
        bus.fu_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.fu_req[i] = pay(base, i);
        end
    endtask

    // Reference round-robin: walk from p, grant up to W valid requesters.
    function automatic void model(input logic [3:0] v, input int p,
                                  output logic [3:0] g, output int np);
        int n;
        int pos;
        n  = 0;
        g  = '0;
        np = p;
        for (int k = 0; k < N; k++) begin
            pos = (p + k) % N;
            if (v[pos] && n < W) begin
                g[pos] = 1'b1;
                n++;
                np = (pos + 1) % N;
            end
        end
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] v;
        logic [3:0] g;
        int         mp;
        int         np;
        int         wait1;

        bus.flush = 1'b0;
        set_fu(4'b0000, 0);

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("rst_cdb_valid", 64'(bus.cdb_valid), 64'(2'b00));
        check("rst_ptr", 64'(bus.rr_ptr_o), 64'(0));
        check("rst_lane0", 64'(bus.cdb_out[0]), 64'(0));
        check("rst_lane1", 64'(bus.cdb_out[1]), 64'(0));
        set_fu(4'b1111, 0);
        #1;
        check("rst_ready_gated", 64'(bus.fu_ready), 64'(4'b0000));
        @(negedge clk);
        set_fu(4'b0000, 0);
        rst = 1'b1;
        #1;
        check("rel_ready", 64'(bus.fu_ready), 64'(4'b0000));
        check("rel_ptr", 64'(bus.rr_ptr_o), 64'(0));

        // Full contention
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            set_fu(4'b1111, 8 * c);
            #1;
            check("cont_ready", 64'(bus.fu_ready), 64'(exp_rdy[c]));
            check("cont_ptr", 64'(bus.rr_ptr_o), 64'(exp_lo[c]));
            @(posedge clk);
            #1;
            check("cont_valid", 64'(bus.cdb_valid), 64'(2'b11));
            check("cont_lane0", 64'(bus.cdb_out[0]), 64'(pay(8 * c, exp_lo[c])));
            check("cont_lane1", 64'(bus.cdb_out[1]), 64'(pay(8 * c, exp_lo[c] + 1)));
        end
        check("cont_ptr_end", 64'(bus.rr_ptr_o), 64'(0));

        // Sparse request
        @(negedge clk);
        set_fu(4'b0100, 40);
        #1;
        check("sparse_ready", 64'(bus.fu_ready), 64'(4'b0100));
        @(posedge clk);
        #1;
        check("sparse_valid", 64'(bus.cdb_valid), 64'(2'b01));
        check("sparse_lane0", 64'(bus.cdb_out[0]), 64'(pay(40, 2)));
        check("sparse_lane1_hold", 64'(bus.cdb_out[1]), 64'(pay(24, 3)));
        check("sparse_ptr", 64'(bus.rr_ptr_o), 64'(3));

        // Idle cycle
        @(negedge clk);
        set_fu(4'b0000, 48);
        #1;
        check("idle_ready", 64'(bus.fu_ready), 64'(4'b0000));
        @(posedge clk);
        #1;
        check("idle_valid", 64'(bus.cdb_valid), 64'(2'b00));
        check("idle_ptr", 64'(bus.rr_ptr_o), 64'(3));

        // Wrap from pointer 3
        @(negedge clk);
        set_fu(4'b1011, 56);
        #1;
        check("wrap_ready", 64'(bus.fu_ready), 64'(4'b1001));
        @(posedge clk);
        #1;
        check("wrap_valid", 64'(bus.cdb_valid), 64'(2'b11));
        check("wrap_lane0", 64'(bus.cdb_out[0]), 64'(pay(56, 3)));
        check("wrap_lane1", 64'(bus.cdb_out[1]), 64'(pay(56, 0)));
        check("wrap_ptr", 64'(bus.rr_ptr_o), 64'(1));

        // Flush with full requests
        @(negedge clk);
        bus.flush = 1'b1;
        set_fu(4'b1111, 64);
        #1;
        check("flush_ready", 64'(bus.fu_ready), 64'(4'b0000));
        @(posedge clk);
        #1;
        check("flush_valid", 64'(bus.cdb_valid), 64'(2'b00));
        check("flush_ptr", 64'(bus.rr_ptr_o), 64'(1));
        check("flush_lane0_hold", 64'(bus.cdb_out[0]), 64'(pay(56, 3)));

        // Resume from the held pointer
        @(negedge clk);
        bus.flush = 1'b0;
        set_fu(4'b1111, 72);
        #1;
        check("resume_ready", 64'(bus.fu_ready), 64'(4'b0110));
        @(posedge clk);
        #1;
        check("resume_valid", 64'(bus.cdb_valid), 64'(2'b11));
        check("resume_lane0", 64'(bus.cdb_out[0]), 64'(pay(72, 1)));
        check("resume_lane1", 64'(bus.cdb_out[1]), 64'(pay(72, 2)));
        check("resume_ptr", 64'(bus.rr_ptr_o), 64'(3));

        // Reset asserted mid-broadcast
        #2 rst = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.cdb_valid), 64'(2'b00));
        check("midrst_ptr", 64'(bus.rr_ptr_o), 64'(0));
        check("midrst_lane0", 64'(bus.cdb_out[0]), 64'(0));
        check("midrst_ready", 64'(bus.fu_ready), 64'(4'b0000));
        @(negedge clk);
        set_fu(4'b0000, 80);
        rst = 1'b1;
        #1;
        check("postrst_ready", 64'(bus.fu_ready), 64'(4'b0000));
        @(posedge clk);
        #1;
        check("postrst_valid", 64'(bus.cdb_valid), 64'(2'b00));
        check("postrst_ptr", 64'(bus.rr_ptr_o), 64'(0));

        // Random requests with requester 1 held valid
        mp    = 0;
        wait1 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            v = 4'($urandom_range(0, 15)) | 4'b0010;
            set_fu(v, 100 + c);
            model(v, mp, g, np);
            #1;
            check("rand_ready", 64'(bus.fu_ready), 64'(g));
            if (bus.fu_ready[1]) begin
                wait1 = 0;
            end else begin
                wait1++;
            end
            check("starve_fu1", 64'(wait1 <= 1), 64'(1));
            mp = np;
            @(posedge clk);
            #1;
            check("rand_ptr", 64'(bus.rr_ptr_o), 64'(mp));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
